y_ctrl_seq: RTL
===============

// Module: y_ctrl_seq
// PURPOSE
//  Multi-cycle control sequencer for the yIF/yID/yEX/yDM datapath; replaces the hand-driven control loop.
//  Owns the PC, steps each instruction through FETCH/DECODE/EXEC/MEM/WB and decodes opcode/funct
//  into datapath controls. Resolves branches and jumps, then stops on HALT, an illegal op or the insn limit.
// PARAMETERS
//  RESET_PC   32'h80  PC loaded on reset and on every start
//  MAX_INSNS  0       retire limit before auto-halt; 0 = unlimited
//  CNT_W      16      width of insn_count
// PORTS
//  clk         in   1      system clock, rising edge
//  rst_n       in   1      asynchronous reset, active-low
//  start       in   1      1-cycle pulse: begin run at RESET_PC (honoured in IDLE/HALT only)
//  ins         in   32     instruction word from yIF at pc_out
//  zero        in   1      ALU zero flag from yEX
//  pc_p4       in   32     pc_out+4 from yIF
//  imm         in   32     sign-extended immediate from yID
//  jtarget     in   26     jump field from yID
//  pc_out      out  32     current PC to yIF
//  ir_ld       out  1      instruction-register load strobe
//  reg_dst     out  1      1 = rd, 0 = rt destination
//  reg_write   out  1      register-file write strobe
//  alu_src     out  1      1 = imm, 0 = rd2
//  alu_op      out  3      0 and, 1 or, 2 add, 6 sub, 7 slt
//  mem_read    out  1      data-memory read enable
//  mem_write   out  1      data-memory write strobe
//  mem2reg     out  1      1 = writeback from memory
//  busy        out  1      high from FETCH until HALT/IDLE
//  halted      out  1      sticky; high in HALT
//  illegal     out  1      sticky; set by an undecodable instruction
//  insn_count  out  CNT_W  retired-instruction count; saturates at all-ones
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, pc_out=RESET_PC, insn_count=0, every other output 0.
//  States: IDLE -start-> FETCH -> DECODE -> EXEC -> {MEM | WB | FETCH} ; MEM -> {WB | FETCH} ; WB -> FETCH.
//  FETCH: ir_ld=1 for 1 cycle; ins is sampled at that edge into an internal IR.
//  DECODE: opcode IR[31:26] and funct IR[5:0] decoded; illegal -> HALT, illegal=1, PC unchanged, no retire.
//  Controls are held constant from EXEC through the last state of the instruction and are 0 in FETCH/DECODE/IDLE/HALT.
//  Exception: reg_write is high only in the WB cycle and mem_write only in the MEM cycle.
//  R-type (op 0; funct 20 add, 22 sub, 24 and, 25 or, 2A slt): reg_dst=1, alu_src=0; EXEC->WB; 4 cycles.
//  addi (08): alu_src=1, alu_op=2; EXEC->WB; 4 cycles.
//  lw (23): alu_src=1, alu_op=2, mem_read=1, mem2reg=1; EXEC->MEM->WB; 5 cycles.
//  sw (2B): alu_src=1, alu_op=2; EXEC->MEM, mem_write in MEM; 4 cycles.
//  beq (04): alu_op=6, alu_src=0; EXEC->FETCH; 3 cycles.
//  j (02): EXEC->FETCH, no ALU use; 3 cycles.
//  HALT (3F): ->HALT, halted=1; not counted as retired.
//  PC update on the final edge of each instruction:
//   - default pc_p4;
//   - beq taken (zero=1): pc_p4 + {imm[29:0],2'b00}, 32-bit wrap;
//   - j: {pc_p4[31:28], jtarget, 2'b00}.
//  Retire (insn_count++) on the same edge. When MAX_INSNS!=0 and the count reaches it -> HALT, halted=1.
//  start ignored while busy. start in HALT/IDLE reloads RESET_PC and clears count, halted, illegal -> FETCH.
//  rst_n low mid-instruction aborts it at once; strobes drop asynchronously; no partial PC or count update.
// CONFIGURATION
//  Y_CTRL_SEQ_BNE_EN defined: opcode 05 (bne) is decoded like beq (alu_op=6, 3 cycles).
//   Branch taken when zero=0.
//  Y_CTRL_SEQ_BNE_EN undefined: opcode 05 is illegal (-> HALT, illegal=1).
// TESTING
//  1 Reset: rst_n=0 mid-EXEC -> pc_out=0x80, all strobes 0, insn_count=0, busy=0 before the next clk edge.
//  2 add $3,$1,$2 (0x00221820) at 0x80, start:
//     ir_ld cycle 1; reg_dst=1, alu_op=2 from cycle 3; reg_write only in cycle 4;
//     pc_out=0x84 after cycle 4; insn_count=1.
//  3 lw then sw:
//     lw: mem_read/mem2reg in EXEC..WB, reg_write cycle 5, 5 cycles total;
//     sw: mem_write one pulse in cycle 4, reg_write never set.
//  4 beq at 0x90, imm=3:
//     zero=1 -> pc_out=0xA0 after 3 cycles; zero=0 -> 0x94.
//     j jtarget=0x20 at 0xA0 -> pc_out=0x80.
//  5 ins=0xFC000000 (HALT), then opcode 05:
//     HALT -> halted=1, busy=0, count unchanged; start pulse -> pc_out=0x80, halted=0.
//     opcode 05 -> illegal=1 without BNE_EN; behaves as bne with BNE_EN.
//  6 MAX_INSNS=3, loop of addi:
//     halted=1 exactly after the 3rd retire, insn_count=3; start while busy has no effect.

Source files
------------

// File: rtl/y_ctrl_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the yIF/yID/yEX/yDM datapath.
// Optional feature: define Y_CTRL_SEQ_BNE_EN to decode opcode 05 as bne.
module y_ctrl_seq #(
  parameter logic [31:0] RESET_PC  = 32'h80,
  parameter int unsigned MAX_INSNS = 0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      ins,
  input  logic             zero,
  input  logic [31:0]      pc_p4,
  input  logic [31:0]      imm,
  input  logic [25:0]      jtarget,
  output logic [31:0]      pc_out,
  output logic             ir_ld,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src,
  output logic [2:0]       alu_op,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem2reg,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] insn_count
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  typedef enum logic [2:0] {K_ALU, K_LW, K_SW, K_BEQ, K_BNE, K_J} kind_t;

  state_t           state, state_nxt;
  kind_t            kind, d_kind;
  logic [31:0]      ir, pc, pc_nxt;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic             illegal_q;
  logic             c_reg_dst, c_alu_src, c_mem_read, c_mem2reg;
  logic [2:0]       c_alu_op;
  logic             d_ok, d_halt, d_reg_dst, d_alu_src, d_mem_read, d_mem2reg;
  logic [2:0]       d_alu_op;
  logic             last, taken, limit_hit, in_ex, idle_like;

  always_comb begin
    d_ok       = 1'b1;
    d_halt     = 1'b0;
    d_kind     = K_ALU;
    d_reg_dst  = 1'b0;
    d_alu_src  = 1'b0;
    d_alu_op   = 3'd0;
    d_mem_read = 1'b0;
    d_mem2reg  = 1'b0;
    case (ir[31:26])
      6'h00: begin
        d_reg_dst = 1'b1;
        case (ir[5:0])
          6'h20:   d_alu_op = 3'd2;
          6'h22:   d_alu_op = 3'd6;
          6'h24:   d_alu_op = 3'd0;
          6'h25:   d_alu_op = 3'd1;
          6'h2A:   d_alu_op = 3'd7;
          default: d_ok = 1'b0;
        endcase
      end
      6'h08: begin d_alu_src = 1'b1; d_alu_op = 3'd2; end
      6'h23: begin
        d_kind = K_LW; d_alu_src = 1'b1; d_alu_op = 3'd2;
        d_mem_read = 1'b1; d_mem2reg = 1'b1;
      end
      6'h2B: begin d_kind = K_SW; d_alu_src = 1'b1; d_alu_op = 3'd2; end
      6'h04: begin d_kind = K_BEQ; d_alu_op = 3'd6; end
`ifdef Y_CTRL_SEQ_BNE_EN
      6'h05: begin d_kind = K_BNE; d_alu_op = 3'd6; end
`endif
      6'h02:   d_kind = K_J;
      6'h3F:   d_halt = 1'b1;
      default: d_ok = 1'b0;
    endcase
  end

  // The retiring edge depends on the instruction class, not on a fixed state.
  always_comb begin
    last = (state == S_WB) ||
           (state == S_MEM  && kind == K_SW) ||
           (state == S_EXEC && (kind == K_BEQ || kind == K_BNE || kind == K_J));
    taken     = (kind == K_BEQ && zero) || (kind == K_BNE && !zero);
    cnt_inc   = (&cnt) ? cnt : cnt + 1'b1;
    limit_hit = (MAX_INSNS != 0) && (cnt_inc == CNT_W'(MAX_INSNS));
    if (kind == K_J)
      pc_nxt = {pc_p4[31:28], jtarget, 2'b00};
    else if (taken)
      pc_nxt = pc_p4 + {imm[29:0], 2'b00};
    else
      pc_nxt = pc_p4;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_HALT: if (start) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: state_nxt = (d_halt || !d_ok) ? S_HALT : S_EXEC;
      S_EXEC:   if (kind == K_ALU) state_nxt = S_WB;
                else if (kind == K_LW || kind == K_SW) state_nxt = S_MEM;
      S_MEM:    if (kind == K_LW) state_nxt = S_WB;
      default:  state_nxt = state;
    endcase
    if (last) state_nxt = limit_hit ? S_HALT : S_FETCH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      kind       <= K_ALU;
      ir         <= '0;
      pc         <= RESET_PC;
      cnt        <= '0;
      illegal_q  <= 1'b0;
      c_reg_dst  <= 1'b0;
      c_alu_src  <= 1'b0;
      c_alu_op   <= '0;
      c_mem_read <= 1'b0;
      c_mem2reg  <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == S_IDLE || state == S_HALT) && start) begin
        pc        <= RESET_PC;
        cnt       <= '0;
        illegal_q <= 1'b0;
      end
      if (state == S_FETCH) ir <= ins;
      if (state == S_DECODE) begin
        kind       <= d_kind;
        c_reg_dst  <= d_reg_dst;
        c_alu_src  <= d_alu_src;
        c_alu_op   <= d_alu_op;
        c_mem_read <= d_mem_read;
        c_mem2reg  <= d_mem2reg;
        if (!d_ok && !d_halt) illegal_q <= 1'b1;
      end
      if (last) begin
        pc  <= pc_nxt;
        cnt <= cnt_inc;
      end
    end
  end

  always_comb begin
    in_ex      = (state == S_EXEC) || (state == S_MEM) || (state == S_WB);
    idle_like  = (state == S_IDLE) || (state == S_HALT);
    pc_out     = pc;
    ir_ld      = (state == S_FETCH);
    reg_dst    = in_ex && c_reg_dst;
    alu_src    = in_ex && c_alu_src;
    alu_op     = in_ex ? c_alu_op : 3'd0;
    mem_read   = in_ex && c_mem_read;
    mem2reg    = in_ex && c_mem2reg;
    reg_write  = (state == S_WB);
    mem_write  = (state == S_MEM) && (kind == K_SW);
    busy       = !idle_like;
    halted     = (state == S_HALT);
    illegal    = illegal_q;
    insn_count = cnt;
  end

endmodule
